// File: rtl/mem_copy_ctrl_if.sv
// Request/memory bus for mem_copy_ctrl.
//   slave  : controller side (takes the request, drives the memory ports).
//   master : requester / memory-model side.
// Request: start, mode, src, dst, len.
// Memory : addr/addr2/write_data/MemRead/MemWrite out, read_data/read_data2 in
//          (both reads combinational from their addresses).
// Status : busy, done, err, mism_cnt, first_mism.
interface mem_copy_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [5:0]    len;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr2;
  logic [DW-1:0] write_data;
  logic          MemRead;
  logic          MemWrite;
  logic [DW-1:0] read_data;
  logic [DW-1:0] read_data2;
  logic          busy;
  logic          done;
  logic          err;
  logic [5:0]    mism_cnt;
  logic [AW-1:0] first_mism;

  modport slave (
    input  start, mode, src, dst, len, read_data, read_data2,
    output addr, addr2, write_data, MemRead, MemWrite,
           busy, done, err, mism_cnt, first_mism
  );

  modport master (
    output start, mode, src, dst, len, read_data, read_data2,
    input  addr, addr2, write_data, MemRead, MemWrite,
           busy, done, err, mism_cnt, first_mism
  );
endinterface

// File: rtl/mem_copy_ctrl.sv
// Word-by-word memory copy / compare controller.
//   clk, rst : rising-edge clock, asynchronous active-high reset.
//   bus      : mem_copy_ctrl_if.slave (request in, memory ports out, status).
// Copy   : RD(src+i) -> WR(dst+i) per word, 2*len+1 cycles start to done.
// Compare: one CMP cycle per word reading both ports, len+1 cycles.
// Every output is a flop, or a decode of flops, so reset clears them
// without waiting for a clock edge.
module mem_copy_ctrl #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_copy_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WR, CMP, DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] src_q, dst_q, addr_q, addr2_q, first_q;
  logic [5:0]    len_q, i_q, mism_q;
  logic [DW-1:0] hold_q;
  logic          rd_q, wr_q, busy_q, done_q, err_q;

  logic [5:0]    i_nxt;
  logic          more;

  assign i_nxt = i_q + 6'd1;
  assign more  = i_nxt < len_q;

  // mode is not kept: it only selects RD vs CMP on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      addr2_q <= '0;
      mism_q  <= '0;
      first_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Memory enables, addresses and pulses default low; each state sets
      // up the outputs of the state it hands over to.
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      addr2_q <= '0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            if (bus.len > 6'd32) begin
              err_q <= 1'b1;
            end else if (bus.len == 6'd0) begin
              state_q <= DONE;
              busy_q  <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              src_q   <= bus.src;
              dst_q   <= bus.dst;
              len_q   <= bus.len;
              i_q     <= '0;
              mism_q  <= '0;
              first_q <= '0;
              busy_q  <= 1'b1;
              rd_q    <= 1'b1;
              addr_q  <= bus.src;
              if (bus.mode) begin
                state_q <= CMP;
                addr2_q <= bus.dst;
              end else begin
                state_q <= RD;
              end
            end
          end
        end
        RD: begin
          hold_q  <= bus.read_data;
          wr_q    <= 1'b1;
          addr_q  <= dst_q + AW'(i_q);
          state_q <= WR;
        end
        WR: begin
          i_q <= i_nxt;
          if (more) begin
            state_q <= RD;
            rd_q    <= 1'b1;
            addr_q  <= src_q + AW'(i_nxt);
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        CMP: begin
          if (bus.read_data != bus.read_data2) begin
            mism_q <= mism_q + 6'd1;
            if (mism_q == 6'd0) first_q <= AW'(i_q);
          end
          i_q <= i_nxt;
          if (more) begin
            rd_q    <= 1'b1;
            addr_q  <= src_q + AW'(i_nxt);
            addr2_q <= dst_q + AW'(i_nxt);
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr2      = addr2_q;
  assign bus.write_data = (state_q == WR) ? hold_q : '0;
  assign bus.MemRead    = rd_q;
  assign bus.MemWrite   = wr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.mism_cnt   = mism_q;
  assign bus.first_mism = first_q;
endmodule
